// File: rtl/spi_slave_ctrl_pkg.sv
// Shared types and constants for the parametrised SPI slave.
// State encoding, SPI mode decode and legal parameter ranges.
package spi_slave_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic sample_rise;
        logic shift_rise;
    } edge_sel_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int SYNC_MIN  = 2;
    localparam int SYNC_MAX  = 4;

    // Leading edge is rise for CPOL=0; CPHA=1 moves sampling to the trailing edge.
    function automatic edge_sel_t mode_decode(input logic cpol, input logic cpha);
        edge_sel_t sel;
        sel.sample_rise = ~(cpol ^ cpha);
        sel.shift_rise  = cpol ^ cpha;
        return sel;
    endfunction

endpackage

// File: rtl/spi_slave_ctrl_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall
// detection taken from the last two synchronised samples.
module spi_pin_sync
    import spi_slave_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    if (STAGES < SYNC_MIN || STAGES > SYNC_MAX) begin : g_bad_stages
        $error("spi_pin_sync: STAGES out of range");
    end

    // Synchroniser chain plus the extra flop used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_ctrl.sv
// Full-duplex SPI slave, WIDTH bits per word, mode set by CPOL/CPHA.
// Define SPI_SLAVE_CTRL_STATUS_EN for rx_overrun/tx_underrun flags and the i_rx_ack port.
module spi_slave_ctrl
    import spi_slave_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sclk,
    input  logic             i_ssel,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
`ifdef SPI_SLAVE_CTRL_STATUS_EN
    input  logic             i_rx_ack,
`endif
    output logic             o_tx_ready,
    output logic             o_busy,
    output logic             o_rx_overrun,
    output logic             o_tx_underrun
);

    localparam int        CNT_W    = $clog2(WIDTH);
    localparam edge_sel_t EDGE_SEL = mode_decode(CPOL, CPHA);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("spi_slave_ctrl: WIDTH out of range");
    end

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_ssel_q, w_ssel_rise, w_ssel_fall;
    logic w_mosi_q, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (i_sclk),
        .o_q    (w_sclk_q),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssel (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (i_ssel),
        .o_q    (w_ssel_q),
        .o_rise (w_ssel_rise),
        .o_fall (w_ssel_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (i_mosi),
        .o_q    (w_mosi_q),
        .o_rise (w_mosi_rise),
        .o_fall (w_mosi_fall)
    );

    assign w_unused = ^{w_sclk_q, w_mosi_rise, w_mosi_fall};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_rx_shift;
    logic [WIDTH-1:0]   r_tx_shift;
    logic [WIDTH-1:0]   r_hold;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_tx_ready;
    logic               r_rx_valid;
    logic               r_word_done;
    logic               r_skip;
    logic               r_miso;
    logic [2:0]         r_settle;

    logic               w_armed;
    logic               w_enter;
    logic               w_leave;
    logic               w_sample;
    logic               w_shift;
    logic               w_last_bit;
    logic [WIDTH-1:0]   w_load_word;

    // A low ssel already present at reset release must not look like a new frame.
    assign w_armed = (r_settle == 3'(SYNC_STAGES + 1));

    // Counts synchroniser fill time after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= 3'd0;
        end else if (!w_armed) begin
            r_settle <= r_settle + 3'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_leave     = 1'b0;
        w_sample    = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ssel_fall && w_armed) begin
                    w_state_nxt = ST_ACTIVE;
                    w_enter     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_ssel_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_leave     = 1'b1;
                end else begin
                    w_sample = EDGE_SEL.sample_rise ? w_sclk_rise : w_sclk_fall;
                    w_shift  = EDGE_SEL.shift_rise  ? w_sclk_rise : w_sclk_fall;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_last_bit  = w_sample && (r_bit_cnt == CNT_W'(WIDTH - 1));
    assign w_load_word = r_tx_ready ? {WIDTH{1'b0}} : r_hold;

    // Transmit holding register and its valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= {WIDTH{1'b0}};
            r_tx_ready <= 1'b1;
        end else if ((w_enter || w_last_bit) && !r_tx_ready) begin
            r_tx_ready <= 1'b1;
        end else if (i_tx_valid && r_tx_ready) begin
            r_hold     <= i_tx_data;
            r_tx_ready <= 1'b0;
        end
    end

    // Shift registers, bit counter and miso.
    // r_skip marks the first shift edge after a word load: present the MSB, do not shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= {CNT_W{1'b0}};
            r_rx_shift <= {WIDTH{1'b0}};
            r_tx_shift <= {WIDTH{1'b0}};
            r_skip     <= 1'b0;
            r_miso     <= 1'b0;
        end else if (w_enter) begin
            r_bit_cnt  <= {CNT_W{1'b0}};
            r_tx_shift <= w_load_word;
            r_miso     <= w_load_word[WIDTH-1];
            r_skip     <= CPHA;
        end else if (w_leave) begin
            r_bit_cnt <= {CNT_W{1'b0}};
            r_miso    <= 1'b0;
            r_skip    <= 1'b0;
        end else if (w_sample) begin
            r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi_q};
            if (w_last_bit) begin
                r_bit_cnt  <= {CNT_W{1'b0}};
                r_tx_shift <= w_load_word;
                r_skip     <= 1'b1;
            end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end else if (w_shift) begin
            if (r_skip) begin
                r_skip <= 1'b0;
                r_miso <= r_tx_shift[WIDTH-1];
            end else begin
                r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
                r_miso     <= r_tx_shift[WIDTH-2];
            end
        end
    end

    // Completed word is published one cycle after its last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_done <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= {WIDTH{1'b0}};
        end else begin
            r_word_done <= w_last_bit;
            r_rx_valid  <= r_word_done;
            if (r_word_done) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

`ifdef SPI_SLAVE_CTRL_STATUS_EN
    logic r_rx_pending;
    logic r_rx_overrun;
    logic r_tx_underrun;

    // Sticky status; a frame start clears them, but an empty load at that start still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_pending  <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            if (r_word_done) begin
                r_rx_pending <= 1'b1;
            end else if (i_rx_ack) begin
                r_rx_pending <= 1'b0;
            end
            if (w_enter) begin
                r_rx_overrun <= 1'b0;
            end else if (r_word_done && r_rx_pending && !i_rx_ack) begin
                r_rx_overrun <= 1'b1;
            end
            if (w_enter) begin
                r_tx_underrun <= r_tx_ready;
            end else if (w_last_bit && r_tx_ready) begin
                r_tx_underrun <= 1'b1;
            end
        end
    end

    assign o_rx_overrun  = r_rx_overrun;
    assign o_tx_underrun = r_tx_underrun;
`else
    assign o_rx_overrun  = 1'b0;
    assign o_tx_underrun = 1'b0;
`endif

    assign o_miso     = r_miso;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_tx_ready = r_tx_ready;
    assign o_busy     = ~w_ssel_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench: a mode-0 8-bit slave driven from a vector table, a mode-3
// 16-bit slave for back-to-back words, and a mid-frame reset sequence.
module tb_spi_slave_ctrl;

    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk0, ssel0, mosi0, miso0, rxv0, txv0, txr0, busy0, ovr0, und0;
    logic [7:0]  rxd0, txd0;
    logic        sclk3, ssel3, mosi3, miso3, rxv3, txv3, txr3, busy3, ovr3, und3;
    logic [15:0] rxd3, txd3;
`ifdef SPI_SLAVE_CTRL_STATUS_EN
    logic        ack0 = 1'b0;
    logic        ack3 = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cnt0    = 0;
    int cnt3    = 0;
    int rdy3_rises = 0;
    logic rdy3_prev = 1'b1;
    logic [15:0] log3 [0:15];

    always #5 clk = ~clk;

    spi_slave_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .i_sclk(sclk0), .i_ssel(ssel0), .i_mosi(mosi0),
        .o_miso(miso0), .o_rx_data(rxd0), .o_rx_valid(rxv0), .i_tx_data(txd0),
        .i_tx_valid(txv0),
`ifdef SPI_SLAVE_CTRL_STATUS_EN
        .i_rx_ack(ack0),
`endif
        .o_tx_ready(txr0), .o_busy(busy0), .o_rx_overrun(ovr0), .o_tx_underrun(und0)
    );

    spi_slave_ctrl #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .i_sclk(sclk3), .i_ssel(ssel3), .i_mosi(mosi3),
        .o_miso(miso3), .o_rx_data(rxd3), .o_rx_valid(rxv3), .i_tx_data(txd3),
        .i_tx_valid(txv3),
`ifdef SPI_SLAVE_CTRL_STATUS_EN
        .i_rx_ack(ack3),
`endif
        .o_tx_ready(txr3), .o_busy(busy3), .o_rx_overrun(ovr3), .o_tx_underrun(und3)
    );

    always @(negedge clk) begin
        if (rxv0) cnt0++;
        if (rxv3) begin
            log3[cnt3 % 16] = rxd3;
            cnt3++;
        end
        if (txr3 && !rdy3_prev) rdy3_rises++;
        rdy3_prev = txr3;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push0(input logic [7:0] w);
        int t = 0;
        @(negedge clk);
        while (!txr0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("push0_ready_timeout", 32'(txr0), 32'd1);
        txd0 = w;
        txv0 = 1'b1;
        @(negedge clk);
        txv0 = 1'b0;
    endtask

    task automatic push3(input logic [15:0] w);
        int t = 0;
        @(negedge clk);
        while (!txr3 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("push3_ready_timeout", 32'(txr3), 32'd1);
        txd3 = w;
        txv3 = 1'b1;
        @(negedge clk);
        txv3 = 1'b0;
    endtask

    // Mode-0 master: data changes on sclk fall, both sides sample on rise.
    task automatic m0_frame(input logic [7:0] mw, input int nbits, input bit end_frame,
                            output logic [7:0] rw);
        logic [7:0] sh = mw;
        rw    = 8'h00;
        ssel0 = 1'b0;
        mosi0 = sh[7];
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            rw    = {rw[6:0], miso0};
            sclk0 = 1'b1;
            #HALF;
            sclk0 = 1'b0;
            sh    = {sh[6:0], 1'b0};
            mosi0 = sh[7];
            #HALF;
        end
        if (end_frame) begin
            ssel0 = 1'b1;
            #(2 * HALF);
        end
    endtask

    // Mode-3 master: idle high, data changes on fall, sample on rise.
    task automatic m3_frame(input logic [31:0] mw, output logic [31:0] rw);
        logic [31:0] sh = mw;
        rw    = 32'h0;
        ssel3 = 1'b0;
        #HALF;
        for (int i = 0; i < 32; i++) begin
            sclk3 = 1'b0;
            mosi3 = sh[31];
            #HALF;
            rw    = {rw[30:0], miso3};
            sclk3 = 1'b1;
            sh    = {sh[30:0], 1'b0};
            #HALF;
        end
        ssel3 = 1'b1;
        #(2 * HALF);
    endtask

    typedef struct {
        logic [7:0] mosi_w;
        int         nbits;
        bit         preload;
        logic [7:0] hold_w;
        int         exp_pulses;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        bit         exp_und;
        bit         exp_ovr;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [7:0]  rd8;
        logic [31:0] rd32;
        int p;
        int r;

        vecs[0] = '{8'hA5, 8, 1'b1, 8'h3C, 1, 8'hA5, 8'h3C, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 5, 1'b1, 8'h77, 0, 8'hA5, 8'h0E, 1'b0, 1'b0};
        vecs[2] = '{8'h81, 8, 1'b0, 8'h00, 1, 8'h81, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'h5A, 8, 1'b1, 8'hC3, 1, 8'h5A, 8'hC3, 1'b1, 1'b1};
        vecs[4] = '{8'hE7, 8, 1'b1, 8'hFF, 1, 8'hE7, 8'hFF, 1'b1, 1'b1};

        rst_n = 1'b0;
        sclk0 = 1'b0; ssel0 = 1'b1; mosi0 = 1'b0; txv0 = 1'b0; txd0 = 8'h00;
        sclk3 = 1'b1; ssel3 = 1'b1; mosi3 = 1'b0; txv3 = 1'b0; txd3 = 16'h0000;
        #20;
        check("reset_rx_data",  32'(rxd0),  32'h0);
        check("reset_rx_valid", 32'(rxv0),  32'h0);
        check("reset_tx_ready", 32'(txr0),  32'h1);
        check("reset_busy",     32'(busy0), 32'h0);
        check("reset_miso",     32'(miso0), 32'h0);
        check("reset_flags",    32'({ovr0, und0}), 32'h0);
        rst_n = 1'b1;
        #80;
        check("idle_busy", 32'(busy0), 32'h0);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].preload) push0(vecs[i].hold_w);
            p = cnt0;
            m0_frame(vecs[i].mosi_w, vecs[i].nbits, 1'b1, rd8);
            check($sformatf("v%0d_rx_pulses", i), 32'(cnt0 - p), 32'(vecs[i].exp_pulses));
            check($sformatf("v%0d_rx_data", i),   32'(rxd0), 32'(vecs[i].exp_rx));
            check($sformatf("v%0d_miso_word", i), 32'(rd8),  32'(vecs[i].exp_miso));
            check($sformatf("v%0d_busy", i),      32'(busy0), 32'h0);
            check($sformatf("v%0d_tx_ready", i),  32'(txr0), 32'h1);
            check($sformatf("v%0d_bit_cnt", i),   32'(u0.r_bit_cnt), 32'h0);
`ifdef SPI_SLAVE_CTRL_STATUS_EN
            check($sformatf("v%0d_underrun", i), 32'(und0), 32'(vecs[i].exp_und));
            check($sformatf("v%0d_overrun", i),  32'(ovr0), 32'(vecs[i].exp_ovr));
`endif
        end

        // Mode 3, two back-to-back 16-bit words in one frame.
        push3(16'hCAFE);
        p = cnt3;
        r = rdy3_rises;
        fork
            m3_frame(32'h1234BEEF, rd32);
            push3(16'h0F0F);
        join
        check("m3_rx_pulses",   32'(cnt3 - p), 32'd2);
        check("m3_word0",       32'(log3[p % 16]), 32'h1234);
        check("m3_word1",       32'(log3[(p + 1) % 16]), 32'hBEEF);
        check("m3_miso_words",  rd32, 32'hCAFE0F0F);
        check("m3_ready_rises", 32'(rdy3_rises - r), 32'd2);
        check("m3_rx_data",     32'(rxd3), 32'hBEEF);
`ifdef SPI_SLAVE_CTRL_STATUS_EN
        check("m3_overrun",  32'(ovr3), 32'h1);
        check("m3_underrun", 32'(und3), 32'h1);
`endif

        // Reset in the middle of a word, then a clean frame.
        push0(8'hFF);
        m0_frame(8'h00, 4, 1'b0, rd8);
        push0(8'h99);
        check("mid_busy",     32'(busy0), 32'h1);
        check("mid_miso",     32'(miso0), 32'h1);
        check("mid_tx_ready", 32'(txr0),  32'h0);
`ifdef SPI_SLAVE_CTRL_STATUS_EN
        check("mid_overrun_cleared", 32'(ovr0), 32'h0);
`endif
        rst_n = 1'b0;
        #1;
        check("rst_rx_data",  32'(rxd0),  32'h0);
        check("rst_rx_valid", 32'(rxv0),  32'h0);
        check("rst_tx_ready", 32'(txr0),  32'h1);
        check("rst_busy",     32'(busy0), 32'h0);
        check("rst_miso",     32'(miso0), 32'h0);
        check("rst_flags",    32'({ovr0, und0}), 32'h0);
        #9;
        #10;
        rst_n = 1'b1;
        #100;
        check("post_rst_no_frame", 32'(u0.r_state), 32'h0);
        ssel0 = 1'b1;
        #80;
        p = cnt0;
        m0_frame(8'h5A, 8, 1'b1, rd8);
        check("post_rst_pulses",  32'(cnt0 - p), 32'd1);
        check("post_rst_rx_data", 32'(rxd0), 32'h5A);
        check("post_rst_miso",    32'(rd8),  32'h00);
`ifdef SPI_SLAVE_CTRL_STATUS_EN
        check("post_rst_underrun", 32'(und0), 32'h1);
        check("post_rst_overrun",  32'(ovr0), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- Parametrised full-duplex SPI slave with word width and mode (CPOL/CPHA) set by parameters.
- Oversamples sclk/ssel/mosi in the system clock domain.
- Delivers received words on a one-cycle valid pulse and accepts transmit words through a valid/ready handshake.
- Sits between the external SPI pins and on-chip register/LED logic; successor to the fixed mode-0, 8-bit, receive-only slave.

Parameters:
- WIDTH, 8: bits per SPI word, 2..32.
- CPOL, 0: idle level of sclk.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- SYNC_STAGES, 2: synchroniser flops per input pin, 2..4. Edge detect uses one extra flop.

Ports:
- clk  in  1  system clock, at least 4x sclk frequency
- rst_n  in  1  asynchronous active-low reset
- sclk  in  1  SPI clock from master (async)
- ssel  in  1  SPI select, active low (async)
- mosi  in  1  master-out data (async)
- miso  out  1  slave-out data
- rx_data  out  WIDTH  last complete received word
- rx_valid  out  1  one-cycle pulse, rx_data updated
- tx_data  in  WIDTH  next word to transmit
- tx_valid  in  1  tx_data offered
- tx_ready  out  1  transmit holding register empty
- busy  out  1  ssel active (synchronised)
- rx_overrun  out  1  status, see Optional Feature
- tx_underrun  out  1  status, see Optional Feature

Behaviour:
- Reset values: rx_data=0, rx_valid=0, tx_ready=1, busy=0, miso=0, flags=0, holding/shift registers=0, bit_cnt=0, state=IDLE.
- All pins pass through SYNC_STAGES flops. Edges are detected from the last two synchronised samples.
- Leading edge = rise if CPOL=0, else fall. Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- Bit order is MSB first for both directions.
- State machine, IDLE -> ACTIVE:
  - Transition on synchronised ssel falling.
  - On entry, load the tx shift register from the holding register if full (tx_ready goes 1 next cycle); otherwise load all-zero.
  - On entry, bit_cnt=0 and miso = shift MSB (required for CPHA=0).
- ACTIVE, sample edge:
  - rx shift <= {rx_shift[WIDTH-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches WIDTH-1 on a sample edge:
    - Next cycle: rx_data <= the completed word, rx_valid=1 for exactly one cycle.
    - bit_cnt wraps to 0.
    - Reload the tx shift register from the holding register, or zero if empty. Back-to-back words need no ssel toggle.
- ACTIVE, shift edge: tx shift shifts left; miso = new MSB.
  - CPHA=1: the first leading edge of a word shifts nothing; miso presents the MSB on that edge instead.
- ACTIVE -> IDLE on synchronised ssel rising:
  - A partial word is discarded; no rx_valid.
  - bit_cnt=0, miso=0. The holding register is kept.
- Transmit handshake:
  - Transfer occurs when tx_valid && tx_ready at a clk edge.
  - tx_ready deasserts the next cycle and reasserts the cycle after the holding register is consumed by a word load.
  - tx_data must be held stable only during the transfer cycle.
- Latency: rx_valid is asserted SYNC_STAGES+2 clk cycles after the final sample edge at the pin.
- rx_data holds its value until the next complete word.
- busy = synchronised ~ssel.
- Asynchronous reset mid-frame returns everything to reset values immediately. The next frame starts only at a fresh ssel falling edge.

Optional Feature:
- Macro: SPI_SLAVE_CTRL_STATUS_EN.
- Defined:
  - rx_overrun is sticky-set when a new word completes while the previous rx_valid has not been acknowledged. Acknowledge is the internal rx_ack pulse, driven by a port rx_ack (in, 1) that exists only under the macro.
  - tx_underrun is sticky-set when a word load finds the holding register empty.
  - Both flags clear on synchronised ssel falling or reset.
- Undefined: rx_overrun=0 and tx_underrun=0 constantly; the rx_ack port is absent.

Decomposition:
- Package spi_slave_pkg:
  - state enum (IDLE, ACTIVE);
  - mode-decode function returning sample/shift edge select from CPOL/CPHA;
  - WIDTH range check constants.
- Sub-module spi_pin_sync: SYNC_STAGES synchroniser plus rise/fall detect for one pin, instantiated three times.

Test Plan:
- Mode 0, WIDTH=8: master sends 0xA5 while tx holds 0x3C -> rx_data=0xA5, one rx_valid pulse, master reads 0x3C.
- Mode 3 (CPOL=1, CPHA=1), WIDTH=16: two back-to-back words 0x1234, 0xBEEF with no ssel toggle -> two rx_valid pulses in order; tx_ready pulses twice after loads.
- ssel deasserted after 5 bits of 0xFF -> no rx_valid, bit_cnt=0; the next full frame 0x81 is received correctly.
- No tx_valid before a frame -> master reads 0x00; tx_underrun=1 with STATUS_EN.
- Two words received without rx_ack (STATUS_EN) -> rx_overrun=1, rx_data=second word; the flag clears on the next ssel fall.
- rst_n low mid-word -> all outputs return to reset values within the same cycle; a following frame 0x5A is received correctly.
